// File: rtl/radar_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : radar_pkg
//  Description : Shared types and constants for the radar point serializer.
//                point_t packs one filtered point as X=[127:96], Y=[95:64],
//                Z=[63:32], ATTR=[31:0]. beat_e numbers the output beats.
//  Revision    : 1.0  initial release
// ============================================================================
package radar_pkg;

    localparam int POINT_W = 128;
    localparam int COORD_W = 32;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
        logic [COORD_W-1:0] attr;
    } point_t;

    typedef enum logic [1:0] {
        BEAT_X    = 2'd0,
        BEAT_Y    = 2'd1,
        BEAT_Z    = 2'd2,
        BEAT_ATTR = 2'd3
    } beat_e;

    // Select the 32-bit field of a point that corresponds to a beat index.
    function automatic logic [COORD_W-1:0] beat_field(input point_t p, input beat_e b);
        logic [COORD_W-1:0] f;
        f = p.x;
        case (b)
            BEAT_X:    f = p.x;
            BEAT_Y:    f = p.y;
            BEAT_Z:    f = p.z;
            BEAT_ATTR: f = p.attr;
            default:   f = p.x;
        endcase
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/radar_point_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : radar_point_serializer_if
//  Description : Bundles the upstream point stream (valid-only, no ready) and
//                the downstream 32-bit valid/ready beat stream.
//                master : serializer side (consumes points, drives beats)
//                slave  : environment side (drives points, accepts beats)
//  Ports       : valid_in, point_in[127:0], m_data[31:0], m_valid, m_ready,
//                m_last, m_beat[1:0]
//  Revision    : 1.0  initial release
// ============================================================================
interface radar_point_serializer_if;
    import radar_pkg::*;

    logic               valid_in;
    logic [POINT_W-1:0] point_in;
    logic [COORD_W-1:0] m_data;
    logic               m_valid;
    logic               m_ready;
    logic               m_last;
    logic [1:0]         m_beat;

    modport master (
        input  valid_in, point_in, m_ready,
        output m_data, m_valid, m_last, m_beat
    );

    modport slave (
        output valid_in, point_in, m_ready,
        input  m_data, m_valid, m_last, m_beat
    );

endinterface
`default_nettype wire

// File: rtl/radar_point_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : radar_point_fifo
//  Description : Synchronous register-array FIFO. Pointers wrap modulo DEPTH;
//                occupancy is kept in a separate level counter so full and
//                empty are unambiguous. The caller guarantees no push when
//                full without a pop, and no pop when empty.
//  Ports       : clk, rst, push, push_data, pop, head (combinational read of
//                the oldest entry), level, full
//  Revision    : 1.0  initial release
// ============================================================================
module radar_point_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 128
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       push,
    input  wire logic [WIDTH-1:0]           push_data,
    input  wire logic                       pop,
    output logic      [WIDTH-1:0]           head,
    output logic      [$clog2(DEPTH):0]     level,
    output logic                            full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + AW'(1);
            if (pop)  r_rptr <= r_rptr + AW'(1);
            case ({push, pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed through valid pointers.
    // When full with a simultaneous pop, wptr == rptr; head is read before the
    // write lands, so the popped entry is returned intact.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wptr] <= push_data;
    end

    assign head  = r_mem[r_rptr];
    assign level = r_level;
    assign full  = (r_level == LW'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/radar_point_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : radar_point_serializer
//  Description : Buffers 128-bit filtered points in a FIFO and emits each as
//                four 32-bit beats (X, Y, Z, ATTR) on a valid/ready stream.
//                Points arriving while the FIFO is full (and not popping) are
//                dropped; overflow is sticky and drop_count saturates.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                bus (master)    - point input and beat output streams
//                fifo_level      - points queued, excluding the output register
//                overflow        - sticky drop flag
//                drop_count      - saturating dropped-point counter
//  Revision    : 1.0  initial release
// ============================================================================
module radar_point_serializer
    import radar_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    radar_point_serializer_if.master           bus,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
    output logic                               overflow,
    output logic [CNT_W-1:0]                   drop_count
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e             r_state, w_state_n;
    beat_e              r_beat,  w_beat_n;
    point_t             r_point, w_point_n;
    logic [COORD_W-1:0] r_data,  w_data_n;
    logic               r_last,  w_last_n;
    logic               r_overflow;
    logic [CNT_W-1:0]   r_drop_count;

    point_t             w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_hs;
    logic               w_pop;
    logic               w_push;

    assign w_empty = (fifo_level == '0);
    assign w_hs    = (r_state == ST_SEND) && bus.m_ready;
    // Reload when idle, or while the final beat is handshaken, so a waiting
    // point follows beat 3 with no bubble.
    assign w_pop   = !w_empty && ((r_state == ST_IDLE) || (w_hs && (r_beat == BEAT_ATTR)));
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push  = bus.valid_in && (!w_full || w_pop);

    radar_point_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (POINT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (bus.point_in),
        .pop       (w_pop),
        .head      (w_head),
        .level     (fifo_level),
        .full      (w_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_beat  <= BEAT_X;
            r_point <= '0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_beat  <= w_beat_n;
            r_point <= w_point_n;
            r_data  <= w_data_n;
            r_last  <= w_last_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_beat_n  = r_beat;
        w_point_n = r_point;
        w_data_n  = r_data;
        w_last_n  = r_last;

        case (r_state)
            ST_IDLE: ;
            ST_SEND: begin
                if (w_hs) begin
                    if (r_beat != BEAT_ATTR) begin
                        w_beat_n = beat_e'(r_beat + 2'd1);
                        w_data_n = beat_field(r_point, w_beat_n);
                        w_last_n = (w_beat_n == BEAT_ATTR);
                    end else begin
                        w_state_n = ST_IDLE;
                        w_beat_n  = BEAT_X;
                        w_data_n  = '0;
                        w_last_n  = 1'b0;
                    end
                end
            end
            default: w_state_n = ST_IDLE;
        endcase

        // Loading the head overrides the idle fall-back above.
        if (w_pop) begin
            w_state_n = ST_SEND;
            w_beat_n  = BEAT_X;
            w_point_n = w_head;
            w_data_n  = w_head.x;
            w_last_n  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (bus.valid_in && !w_push) begin
            r_overflow <= 1'b1;
            if (r_drop_count != '1) r_drop_count <= r_drop_count + CNT_W'(1);
        end
    end

    assign bus.m_valid = (r_state == ST_SEND);
    assign bus.m_data  = r_data;
    assign bus.m_last  = r_last;
    assign bus.m_beat  = r_beat;
    assign overflow    = r_overflow;
    assign drop_count  = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_radar_point_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_radar_point_serializer
//  Description : Scoreboard bench. Stimulus pushes the four expected beats of
//                every accepted point into a queue; a negedge monitor pops and
//                compares on every handshake and checks beat stability while
//                the sink stalls.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_radar_point_serializer;

    logic clk;
    logic rst;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [15:0] drop_count;

    radar_point_serializer_if bus();

    radar_point_serializer #(
        .FIFO_DEPTH (8),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  beat;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int    hs_stamp[$];
    int    checks    = 0;
    int    failures  = 0;
    int    cyc       = 0;
    int    max_level = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [1:0]  prev_beat;
    logic        prev_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] make_pt(input int k);
        return {32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k),
                32'h3000_0000 + 32'(k), 32'h4000_0000 + 32'(k)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one point for one cycle; queue its beats if it should be accepted.
    task automatic push_point(input logic [127:0] p, input bit accept);
        beat_t e;
        bus.valid_in = 1'b1;
        bus.point_in = p;
        if (accept) begin
            for (int b = 0; b < 4; b++) begin
                e.data = p[127-32*b -: 32];
                e.beat = 2'(b);
                e.last = (b == 3);
                sb.push_back(e);
            end
        end
        tick();
        bus.valid_in = 1'b0;
        bus.point_in = '0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check({"drain_", name}, 64'(sb.size()), 64'd0);
        tick();
        tick();
    endtask

    // Monitor: samples on the falling edge, between active edges.
    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            if (prev_stall) begin
                check("hold_valid", 64'(bus.m_valid), 64'd1);
                check("hold_data",  64'(bus.m_data),  64'(prev_data));
                check("hold_beat",  64'(bus.m_beat),  64'(prev_beat));
                check("hold_last",  64'(bus.m_last),  64'(prev_last));
            end
            if (bus.m_valid && bus.m_ready) begin
                hs_stamp.push_back(cyc);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: actual=%0h required=none", bus.m_data);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", 64'(bus.m_data), 64'(e.data));
                    check("beat_idx",  64'(bus.m_beat), 64'(e.beat));
                    check("beat_last", 64'(bus.m_last), 64'(e.last));
                end
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_beat  = bus.m_beat;
            prev_last  = bus.m_last;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    logic [1:0] bp_pat [4];
    int base;

    initial begin
        bp_pat[0] = 2'd1; bp_pat[1] = 2'd0; bp_pat[2] = 2'd0; bp_pat[3] = 2'd1;
        rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.point_in = '0;
        bus.m_ready  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_m_valid",    64'(bus.m_valid), 64'd0);
        check("rst_m_last",     64'(bus.m_last),  64'd0);
        check("rst_m_beat",     64'(bus.m_beat),  64'd0);
        check("rst_m_data",     64'(bus.m_data),  64'd0);
        check("rst_fifo_level", 64'(fifo_level),  64'd0);
        check("rst_overflow",   64'(overflow),    64'd0);
        check("rst_drop_count", 64'(drop_count),  64'd0);

        // Single point: X beat visible two cycles after valid_in
        bus.m_ready = 1'b1;
        base = hs_stamp.size();
        push_point(128'h11111111_22222222_33333333_44444444, 1'b1);
        check("lat_n1_valid", 64'(bus.m_valid), 64'd0);
        check("lat_n1_level", 64'(fifo_level),  64'd1);
        tick();
        check("lat_n2_valid", 64'(bus.m_valid), 64'd1);
        check("lat_n2_data",  64'(bus.m_data),  64'h11111111);
        check("lat_n2_beat",  64'(bus.m_beat),  64'd0);
        wait_drain("single", 20);
        check("single_beats", 64'(hs_stamp.size() - base), 64'd4);
        if (hs_stamp.size() - base == 4)
            check("single_span", 64'(hs_stamp[base+3] - hs_stamp[base]), 64'd3);

        // Backpressure: ready pattern 1,0,0,1 repeating
        bus.m_ready = bp_pat[0][0];
        push_point(128'hAAAA0001_BBBB0002_CCCC0003_DDDD0004, 1'b1);
        for (int i = 1; i < 80 && sb.size() != 0; i++) begin
            bus.m_ready = bp_pat[i % 4][0];
            tick();
        end
        bus.m_ready = 1'b1;
        wait_drain("backpressure", 4);

        // Back-to-back: three points four cycles apart, no gaps
        max_level = 0;
        base = hs_stamp.size();
        push_point(make_pt(1), 1'b1);
        repeat (3) tick();
        push_point(make_pt(2), 1'b1);
        repeat (3) tick();
        push_point(make_pt(3), 1'b1);
        wait_drain("b2b", 40);
        check("b2b_beats", 64'(hs_stamp.size() - base), 64'd12);
        if (hs_stamp.size() - base == 12)
            check("b2b_span", 64'(hs_stamp[base+11] - hs_stamp[base]), 64'd11);
        check("b2b_max_level", 64'(max_level), 64'd1);

        // Overflow: 11 points with the sink stalled; 10th and 11th dropped
        bus.m_ready = 1'b0;
        for (int k = 1; k <= 11; k++) push_point(make_pt(100 + k), k <= 9);
        tick();
        check("ovf_drop_count", 64'(drop_count), 64'd2);
        check("ovf_overflow",   64'(overflow),   64'd1);
        check("ovf_level",      64'(fifo_level), 64'd8);
        check("ovf_m_beat",     64'(bus.m_beat), 64'd0);

        // Full FIFO: push during the last-beat handshake is accepted
        bus.m_ready = 1'b1;
        repeat (3) tick();
        check("sim_beat3", 64'(bus.m_beat), 64'd3);
        push_point(make_pt(112), 1'b1);
        check("sim_level",      64'(fifo_level), 64'd8);
        check("sim_drop_count", 64'(drop_count), 64'd2);
        wait_drain("overflow", 100);
        check("ovf_end_level", 64'(fifo_level),  64'd0);
        check("ovf_end_valid", 64'(bus.m_valid), 64'd0);

        // Reset mid-point with three points queued
        bus.m_ready = 1'b0;
        for (int k = 0; k < 4; k++) push_point(make_pt(200 + k), 1'b1);
        bus.m_ready = 1'b1;
        tick();
        check("pre_rst_beat",  64'(bus.m_beat), 64'd1);
        check("pre_rst_level", 64'(fifo_level), 64'd3);
        rst          = 1'b1;
        bus.m_ready  = 1'b0;
        bus.valid_in = 1'b1;
        bus.point_in = make_pt(300);
        sb.delete();
        tick();
        rst          = 1'b0;
        bus.valid_in = 1'b0;
        bus.point_in = '0;
        check("mid_rst_valid",  64'(bus.m_valid), 64'd0);
        check("mid_rst_level",  64'(fifo_level),  64'd0);
        check("mid_rst_drops",  64'(drop_count),  64'd0);
        check("mid_rst_ovf",    64'(overflow),    64'd0);
        check("mid_rst_beat",   64'(bus.m_beat),  64'd0);
        tick();
        check("post_rst_valid", 64'(bus.m_valid), 64'd0);
        bus.m_ready = 1'b1;
        push_point(make_pt(400), 1'b1);
        wait_drain("post_rst", 20);
        check("post_rst_drops", 64'(drop_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/radar_point_serializer.md
# radar_point_serializer

Output-side consumer of the radar noise-reduction stage. Accepts the 128-bit filtered point stream, which is valid-qualified only and has no backpressure, into a small point FIFO. Each point is emitted as four 32-bit beats on a valid/ready streaming interface toward the fusion interconnect. Points that arrive while the FIFO cannot accept them are dropped and counted; the block never stalls the upstream filter.

## Interface
Parameters:
- FIFO_DEPTH, 8, point slots; power of two, ≥2.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  point_in is valid this cycle; no ready is returned.
- point_in  in  128  point fields: X=[127:96], Y=[95:64], Z=[63:32], ATTR=[31:0].
- m_data  out  32  current beat.
- m_valid  out  1  m_data is valid.
- m_ready  in  1  downstream accepts the beat when m_valid && m_ready.
- m_last  out  1  high on the ATTR beat (beat 3).
- m_beat  out  2  beat index: 0=X, 1=Y, 2=Z, 3=ATTR.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  points held in the FIFO, excluding the point in the output register.
- overflow  out  1  sticky; set on the first dropped point.
- drop_count  out  CNT_W  dropped points; saturates at all-ones.

## Operation
- Push:
  - A point is written when valid_in && (fifo_level < FIFO_DEPTH || pop_this_cycle).
  - Otherwise the point is dropped: overflow←1, and drop_count increments unless already saturated.
- Pop: the FIFO head is loaded into the 128-bit output register when the serializer is IDLE, or when the last beat is being handshaken, and the FIFO is non-empty.
- FSM:
  - IDLE (m_valid=0): if the FIFO is non-empty → SEND with beat=0.
  - SEND (m_valid=1, m_data = field[beat]):
    - On handshake with beat<3 → beat+1.
    - On handshake with beat=3 → if the FIFO is non-empty, reload and go to beat=0 (stay in SEND); else → IDLE.
- m_data, m_beat and m_last must remain stable while m_valid && !m_ready (AXI-stream rule).
- A point being serialized is never overwritten. A valid_in never corrupts the output register.
- Pointer wrap: read/write pointers are log2(FIFO_DEPTH) bits wide and wrap modulo the depth. The level is tracked by a separate counter.
- Simultaneous push and pop: fifo_level is unchanged; the pushed point lands at the tail.
- Reset:
  - State → IDLE, beat=0, pointers and level=0, overflow=0, drop_count=0.
  - m_valid=0, m_last=0, m_beat=0, m_data=0.
  - Reset asserted mid-point discards that point and the entire FIFO contents.
  - valid_in during a reset cycle is ignored and not counted as a drop.
- overflow and drop_count clear only on rst.

## Timing
- Latency, empty FIFO in IDLE: valid_in at cycle N → m_valid=1 with the X beat at N+2. Push at N; the head is loaded into the output register at N+1 and is visible at N+2.
- Throughput: with m_ready held high, consecutive points produce continuous beats with no bubble between beat 3 and the next beat 0.
- Sustained input rate: up to 1 point per 4 cycles without loss. Bursts at a higher rate are absorbed up to FIFO_DEPTH points, plus one point in the output register.
- fifo_level, overflow and drop_count update in the cycle after the triggering event. All outputs are registered.

## Structure
- Shared package radar_pkg:
  - POINT_W=128 and COORD_W=32.
  - point_t packed struct {x, y, z, attr} in the bit order given under Interface.
  - Beat index enum: BEAT_X, BEAT_Y, BEAT_Z, BEAT_ATTR.
- Sub-module radar_point_fifo:
  - Synchronous FIFO with a register array, parameterised by depth and width.
  - Exposes push, pop, head, level and full.
  - The top level holds the FSM, beat counter, output register and drop logic.

## Test plan
- Single point: 0x11111111_22222222_33333333_44444444 in, m_ready=1 → beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 at cycles N+2..N+5; m_last is high only on the 4th beat.
- Backpressure: m_ready toggles 1,0,0,1,… → each beat is held stable while stalled; all four beats are delivered exactly once, in order.
- Back-to-back: 3 points spaced 4 cycles apart, m_ready=1 → 12 contiguous beats with no gap; fifo_level never exceeds 1.
- Overflow (FIFO_DEPTH=8): m_ready=0, 11 points on consecutive cycles → 1 point in the output register and 8 in the FIFO; the 10th and 11th are dropped. Expect drop_count=2, overflow=1, fifo_level=8. After releasing m_ready, points 1–9 emerge in order.
- Full FIFO with simultaneous push and pop: push a point in the same cycle as the last-beat handshake → the point is accepted, drop_count is unchanged, and fifo_level stays at 8.
- Reset mid-point: assert rst during beat 1 with 3 points queued → next cycle m_valid=0, fifo_level=0, drop_count=0, overflow=0. A new point after reset emerges starting at the X beat.
